// File: rtl/usb_out_send_pkg.sv
// Shared USB definitions for the OUT transaction engine: PIDs, device address, status codes.
package usb_out_send_pkg;

    // Full 8-bit PIDs (PID nibble plus its complement check nibble)
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // Address assigned to the motor controller during enumeration
    localparam logic [6:0] USB_DEV_ADDR = 7'h05;

    // Final transaction status reported with done
    localparam logic [1:0] ST_ACK     = 2'd0;
    localparam logic [1:0] ST_NAK     = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

endpackage

// File: rtl/usb_out_send_reg.sv
// Register primitive with asynchronous active-low clear to a fixed init value.
module usb_out_send_reg #(
    parameter int           W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every clock; clear to INIT while rst_n is low
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) q <= INIT;
        else        q <= d;
    end

endmodule

// File: rtl/usb_out_send.sv
// Host-side USB OUT transaction engine: token, DATA0/1 packet, handshake, retry, status.
module usb_out_send
    import usb_out_send_pkg::*;
#(
    parameter logic [3:0]  ENDP      = 4'h1,
    parameter int          MAX_LEN   = 64,
    parameter logic [15:0] TIMEOUT   = 16'h1650,
    parameter int          MAX_RETRY = 3
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        toggle_clr,
    output logic [5:0]  payload_addr,
    input  logic [7:0]  payload_d,
    output logic [18:0] token_d,
    output logic        token_start,
    output logic [7:0]  sie_txd,
    output logic        sie_txdv,
    input  logic        sie_txre,
    input  logic        tx_sie_done,
    input  logic [7:0]  sie_rxd,
    input  logic        sie_rxdv,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_TX_TOKEN      = 4'd1,
        S_TX_TOKEN_WAIT = 4'd2,
        S_TX_DATA       = 4'd3,
        S_TX_DATA_WAIT  = 4'd4,
        S_RX_HS         = 4'd5,
        S_RETRY         = 4'd6,
        S_SUCCESS       = 4'd7,
        S_FAIL          = 4'd8
    } state_t;

    state_t state, state_nxt;

    logic               toggle, toggle_nxt;
    logic               last_to, last_to_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [6:0]         byte_cnt, byte_nxt;
    logic [6:0]         len_q, len_nxt;
    logic [15:0]        to_cnt, to_nxt;
    logic [1:0]         status_q, status_nxt;

    function automatic logic [6:0] clamp_len(input logic [6:0] l);
        if (int'(l) > MAX_LEN) return 7'(MAX_LEN);
        return l;
    endfunction

    // State register; an asserted rst_n abandons any transaction without a done pulse
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    usb_out_send_reg #(.W(1))       u_toggle  (.c(c), .rst_n(rst_n), .d(toggle_nxt),  .q(toggle));
    usb_out_send_reg #(.W(1))       u_last_to (.c(c), .rst_n(rst_n), .d(last_to_nxt), .q(last_to));
    usb_out_send_reg #(.W(RETRY_W)) u_retry   (.c(c), .rst_n(rst_n), .d(retry_nxt),   .q(retry_cnt));
    usb_out_send_reg #(.W(7))       u_byte    (.c(c), .rst_n(rst_n), .d(byte_nxt),    .q(byte_cnt));
    usb_out_send_reg #(.W(7))       u_len     (.c(c), .rst_n(rst_n), .d(len_nxt),     .q(len_q));
    usb_out_send_reg #(.W(16))      u_to      (.c(c), .rst_n(rst_n), .d(to_nxt),      .q(to_cnt));
    usb_out_send_reg #(.W(2))       u_status  (.c(c), .rst_n(rst_n), .d(status_nxt),  .q(status_q));

    assign token_d = {ENDP, USB_DEV_ADDR, PID_OUT};
    assign busy    = (state != S_IDLE);
    assign status  = status_q;

    // Next-state, datapath register updates and per-state outputs
    always_comb begin
        state_nxt    = state;
        toggle_nxt   = toggle;
        last_to_nxt  = last_to;
        retry_nxt    = retry_cnt;
        byte_nxt     = byte_cnt;
        len_nxt      = len_q;
        to_nxt       = to_cnt;
        status_nxt   = status_q;
        token_start  = 1'b0;
        sie_txdv     = 1'b0;
        sie_txd      = 8'h00;
        payload_addr = 6'd0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (toggle_clr) toggle_nxt = 1'b0;
                if (start) begin
                    len_nxt   = clamp_len(len);
                    retry_nxt = '0;
                    state_nxt = S_TX_TOKEN;
                end
            end
            S_TX_TOKEN: begin
                token_start = 1'b1;
                state_nxt   = S_TX_TOKEN_WAIT;
            end
            S_TX_TOKEN_WAIT: begin
                if (tx_sie_done) begin
                    byte_nxt  = 7'd0;
                    state_nxt = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                // Index 0 is the data PID; payload byte i goes out at index i+1
                sie_txdv = 1'b1;
                if (byte_cnt == 7'd0) begin
                    sie_txd = toggle ? PID_DATA1 : PID_DATA0;
                end else begin
                    sie_txd      = payload_d;
                    payload_addr = 6'(byte_cnt - 7'd1);
                end
                if (sie_txre) begin
                    byte_nxt = byte_cnt + 7'd1;
                    if (byte_cnt == len_q) state_nxt = S_TX_DATA_WAIT;
                end
            end
            S_TX_DATA_WAIT: begin
                if (tx_sie_done) begin
                    to_nxt    = 16'd0;
                    state_nxt = S_RX_HS;
                end
            end
            S_RX_HS: begin
                to_nxt = to_cnt + 16'd1;
                if (sie_rxdv) begin
                    case (sie_rxd)
                        PID_ACK: begin
                            toggle_nxt = ~toggle;
                            status_nxt = ST_ACK;
                            state_nxt  = S_SUCCESS;
                        end
                        PID_NAK: begin
                            last_to_nxt = 1'b0;
                            state_nxt   = S_RETRY;
                        end
                        PID_STALL: begin
                            status_nxt = ST_STALL;
                            state_nxt  = S_FAIL;
                        end
                        default: begin
                            status_nxt = ST_TIMEOUT;
                            state_nxt  = S_FAIL;
                        end
                    endcase
                end else if (to_cnt >= TIMEOUT) begin
                    last_to_nxt = 1'b1;
                    state_nxt   = S_RETRY;
                end
            end
            S_RETRY: begin
                // Toggle stays put: the device has not accepted this packet yet
                if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                    retry_nxt = retry_cnt + 1'b1;
                    state_nxt = S_TX_TOKEN;
                end else begin
                    status_nxt = last_to ? ST_TIMEOUT : ST_NAK;
                    state_nxt  = S_FAIL;
                end
            end
            S_SUCCESS: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAIL: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_out_send.sv
// Scoreboard bench for usb_out_send with a simple SIE/device responder.
module tb_usb_out_send;
    import usb_out_send_pkg::*;

    localparam int TMO = 'h1650;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  len = 7'd0;
    logic        toggle_clr = 1'b0;
    logic [5:0]  payload_addr;
    logic [7:0]  payload_d;
    logic [18:0] token_d;
    logic        token_start;
    logic [7:0]  sie_txd;
    logic        sie_txdv;
    logic        sie_txre = 1'b1;
    logic        tx_sie_done = 1'b0;
    logic [7:0]  sie_rxd = 8'h00;
    logic        sie_rxdv = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    logic [7:0]  pbuf [64];
    logic [7:0]  hs_pid [4];   // 8'h00 means the device stays silent
    logic [7:0]  exp_tx [$];
    logic [1:0]  exp_st [$];
    int          total = 0;
    int          bad = 0;
    int          tok_cnt = 0;
    int          tok_base = 0;
    int          send_seq = 0;
    int          r_last_seq = 0;
    int          r_att = 0;

    always #4 c = ~c;

    assign payload_d = pbuf[payload_addr];

    usb_out_send dut (
        .c(c), .rst_n(rst_n), .start(start), .len(len), .toggle_clr(toggle_clr),
        .payload_addr(payload_addr), .payload_d(payload_d), .token_d(token_d),
        .token_start(token_start), .sie_txd(sie_txd), .sie_txdv(sie_txdv),
        .sie_txre(sie_txre), .tx_sie_done(tx_sie_done), .sie_rxd(sie_rxd),
        .sie_rxdv(sie_rxdv), .busy(busy), .done(done), .status(status)
    );

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_hs(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3);
        hs_pid[0] = p0; hs_pid[1] = p1; hs_pid[2] = p2; hs_pid[3] = p3;
    endtask

    task automatic begin_send(input int n_req, input int n_eff, input logic [7:0] pid,
                              input int attempts, input logic [1:0] st);
        send_seq++;
        for (int a = 0; a < attempts; a++) begin
            exp_tx.push_back(pid);
            for (int i = 0; i < n_eff; i++) exp_tx.push_back(pbuf[i]);
        end
        exp_st.push_back(st);
        tok_base = tok_cnt;
        len   = 7'(n_req);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("token_latency", token_start, 1);
    endtask

    task automatic finish_send(input int attempts, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_wait: got no done in %0d cycles, expected done", budget);
        end
        repeat (2) tick();
        check("token_count", tok_cnt - tok_base, attempts);
        check("tx_left", exp_tx.size(), 0);
        check("st_left", exp_st.size(), 0);
        repeat (3) tick();
    endtask

    // Monitor: pops expected bytes/status as the DUT presents them
    initial forever begin
        @(negedge c);
        if (rst_n) begin
            if (token_start) tok_cnt++;
            if (sie_txdv && sie_txre) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_extra: got %02h expected no byte", sie_txd);
                end else begin
                    check("tx_byte", sie_txd, exp_tx.pop_front());
                end
            end
            if (done) begin
                if (exp_st.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_extra: got status %0d expected no done", status);
                end else begin
                    check("status", status, exp_st.pop_front());
                end
            end
        end
    end

    // SIE/device model: finishes token and data packets, then answers from hs_pid
    initial forever begin
        int k;
        tick();
        if (token_start) begin
            if (send_seq != r_last_seq) begin
                r_last_seq = send_seq;
                r_att = 0;
            end
            repeat (3) tick();
            tx_sie_done = 1'b1;
            tick();
            tx_sie_done = 1'b0;
            k = 0;
            while (!sie_txdv && k < 200) begin tick(); k++; end
            k = 0;
            while (sie_txdv && k < 400) begin tick(); k++; end
            repeat (2) tick();
            tx_sie_done = 1'b1;
            tick();
            tx_sie_done = 1'b0;
            if (r_att < 4 && hs_pid[r_att] != 8'h00) begin
                repeat (20) tick();
                sie_rxd  = hs_pid[r_att];
                sie_rxdv = 1'b1;
                tick();
                sie_rxdv = 1'b0;
            end
            r_att++;
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 64; i++) pbuf[i] = 8'(8'h50 + i);
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33; pbuf[3] = 8'h44;
        set_hs(8'h00, 8'h00, 8'h00, 8'h00);

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_token_start", token_start, 0);
        check("rst_txdv", sie_txdv, 0);
        check("rst_addr", payload_addr, 0);
        check("rst_status", status, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("token_d", token_d, {4'h1, 7'h05, 8'hE1});

        // len=4 ACK: DATA0 then toggle flips
        set_hs(8'hD2, 8'h00, 8'h00, 8'h00);
        begin_send(4, 4, 8'hC3, 1, 2'd0);
        finish_send(1, 500);
        begin_send(3, 3, 8'h4B, 1, 2'd0);
        finish_send(1, 500);
        // zero-length packet
        begin_send(0, 0, 8'hC3, 1, 2'd0);
        finish_send(1, 500);
        // toggle_clr forces DATA0 although toggle is 1
        toggle_clr = 1'b1;
        tick();
        toggle_clr = 1'b0;
        begin_send(1, 1, 8'hC3, 1, 2'd0);
        finish_send(1, 500);

        // NAK four times: four identical attempts, toggle unchanged
        set_hs(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        begin_send(2, 2, 8'h4B, 4, 2'd1);
        finish_send(4, 2000);
        // STALL on the first attempt
        set_hs(8'h1E, 8'h00, 8'h00, 8'h00);
        begin_send(1, 1, 8'h4B, 1, 2'd2);
        finish_send(1, 500);

        // Silent device: exact wait before the retry token, then status 3
        set_hs(8'h00, 8'h00, 8'h00, 8'h00);
        begin_send(0, 0, 8'h4B, 4, 2'd3);
        k = 0;
        while (!sie_txdv && k < 200) begin tick(); k++; end
        k = 0;
        while (sie_txdv && k < 200) begin tick(); k++; end
        k = 0;
        while (!token_start && k < 10000) begin tick(); k++; end
        check("timeout_gap", k, TMO + 5);
        finish_send(4, 30000);

        // len above MAX_LEN is clamped to 64
        set_hs(8'hD2, 8'h00, 8'h00, 8'h00);
        begin_send(70, 64, 8'h4B, 1, 2'd0);
        finish_send(1, 1000);

        // SIE back-pressure mid-payload; a start while busy is ignored
        begin_send(4, 4, 8'hC3, 1, 2'd0);
        k = 0;
        while (!(sie_txdv && payload_addr == 6'd1) && k < 100) begin tick(); k++; end
        sie_txre = 1'b0;
        check("stall_txd0", sie_txd, 8'h22);
        start = 1'b1;
        len = 7'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            check("stall_txd", sie_txd, 8'h22);
            check("stall_addr", payload_addr, 1);
        end
        sie_txre = 1'b1;
        finish_send(1, 500);

        // Unknown handshake PID
        set_hs(8'h69, 8'h00, 8'h00, 8'h00);
        begin_send(2, 2, 8'h4B, 1, 2'd3);
        finish_send(1, 500);

        // Reset in TX_DATA: abort without done, toggle back to 0
        set_hs(8'h00, 8'h00, 8'h00, 8'h00);
        begin_send(4, 4, 8'h4B, 1, 2'd0);
        k = 0;
        while (!(sie_txdv && payload_addr == 6'd2) && k < 100) begin tick(); k++; end
        rst_n = 1'b0;
        #1;
        check("abort_txdv", sie_txdv, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_done", done, 0);
        end
        rst_n = 1'b1;
        exp_tx.delete();
        exp_st.delete();
        repeat (10) tick();
        set_hs(8'hD2, 8'h00, 8'h00, 8'h00);
        begin_send(0, 0, 8'hC3, 1, 2'd0);
        finish_send(1, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
